// File: rtl/exu_wb_arb.sv
// Writeback arbiter: per-unit result FIFOs drained round-robin into one
// registered register-file write port, with backpressure and pending-rd mask.
module exu_wb_arb #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 5,
  parameter int DEPTH   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*XLEN-1:0] i_req_data,
  input  logic [NUM_REQ*5-1:0]    i_req_rd_addr,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [XLEN-1:0]         o_wb_data,
  output logic [4:0]              o_wb_rd_addr,
  output logic                    o_wb_rd_wr_en,
  output logic [2:0]              o_wb_src,
  output logic [31:0]             o_pend_mask,
  output logic                    o_arb_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_data [NUM_REQ][DEPTH];
  logic [4:0]      r_rd   [NUM_REQ][DEPTH];
  logic [AW-1:0]   r_wptr [NUM_REQ];
  logic [AW-1:0]   r_rptr [NUM_REQ];
  logic [CW-1:0]   r_cnt  [NUM_REQ];
  logic [2:0]      r_lastGrant;
  logic [XLEN-1:0] r_wbData;
  logic [4:0]      r_wbRd;
  logic            r_wbWrEn;
  logic [2:0]      r_wbSrc;

  logic [NUM_REQ-1:0] w_nonEmpty;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic               w_grantValid;
  logic [2:0]         w_grantIdx;
  logic [XLEN-1:0]    w_headData;
  logic [4:0]         w_headRd;
  logic [31:0]        w_pendMask;

  // Ready looks only at the registered count: a full FIFO refuses even when it is popped this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_nonEmpty[i]  = (r_cnt[i] != '0);
      o_req_ready[i] = (r_cnt[i] != CW'(DEPTH));
      w_push[i]      = i_req_valid[i] & o_req_ready[i];
      w_pop[i]       = w_grantValid && (w_grantIdx == 3'(i));
    end
  end

  always_comb begin
    logic [2:0] idx;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    idx          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 3'((int'(r_lastGrant) + k) % NUM_REQ);
      if (!w_grantValid && w_nonEmpty[idx]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = idx;
      end
    end
  end

  assign w_headData = r_data[w_grantIdx][r_rptr[w_grantIdx]];
  assign w_headRd   = r_rd[w_grantIdx][r_rptr[w_grantIdx]];

  // x0 destinations never need a hazard stall, so they are left out of the mask.
  always_comb begin
    logic [AW-1:0] slot;
    w_pendMask = '0;
    slot       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < r_cnt[i]) begin
          slot = r_rptr[i] + AW'(k);
          if (r_rd[i][slot] != 5'd0) begin
            w_pendMask[r_rd[i][slot]] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_push[i]) begin
        r_data[i][r_wptr[i]] <= i_req_data[i*XLEN +: XLEN];
        r_rd[i][r_wptr[i]]   <= i_req_rd_addr[i*5 +: 5];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_lastGrant <= 3'(NUM_REQ - 1);
      r_wbData    <= '0;
      r_wbRd      <= '0;
      r_wbWrEn    <= 1'b0;
      r_wbSrc     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      if (w_grantValid) begin
        r_lastGrant <= w_grantIdx;
        r_wbData    <= w_headData;
        r_wbRd      <= w_headRd;
        r_wbWrEn    <= (w_headRd != 5'd0);
        r_wbSrc     <= w_grantIdx;
      end else begin
        r_wbWrEn <= 1'b0;
      end
    end
  end

  assign o_wb_data     = r_wbData;
  assign o_wb_rd_addr  = r_wbRd;
  assign o_wb_rd_wr_en = r_wbWrEn;
  assign o_wb_src      = r_wbSrc;
  assign o_pend_mask   = w_pendMask;
  assign o_arb_busy    = |w_nonEmpty;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Bench for exu_wb_arb: queue-based reference model feeds a beat scoreboard
// that an independent monitor drains against the writeback port.
module tb_exu_wb_arb;

  localparam int XLEN  = 32;
  localparam int NREQ  = 5;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  src;
  } beat_t;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      reqValid;
  logic [NREQ*XLEN-1:0] reqData;
  logic [NREQ*5-1:0]    reqRd;
  logic [NREQ-1:0]      reqReady;
  logic [XLEN-1:0]      wbData;
  logic [4:0]           wbRd;
  logic                 wbWrEn;
  logic [2:0]           wbSrc;
  logic [31:0]          pendMask;
  logic                 arbBusy;

  entry_t modelQ [NREQ][$];
  beat_t  sb[$];
  int     modelLast = NREQ - 1;
  int     heldSrc = 0;
  bit     modelValid = 0;
  bit     justReset = 0;
  int     cycleCount = 0;
  int     checksTotal = 0;
  int     checksPassed = 0;

  logic [4:0]   v;
  logic [159:0] d;
  logic [24:0]  r;
  logic [4:0]   acc;

  exu_wb_arb #(.XLEN(XLEN), .NUM_REQ(NREQ), .DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(reqValid),
    .i_req_data(reqData),
    .i_req_rd_addr(reqRd),
    .o_req_ready(reqReady),
    .o_wb_data(wbData),
    .o_wb_rd_addr(wbRd),
    .o_wb_rd_wr_en(wbWrEn),
    .o_wb_src(wbSrc),
    .o_pend_mask(pendMask),
    .o_arb_busy(arbBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
  endtask

  // Every writeback beat must match the oldest expected beat, including the cycle it lands in.
  always @(negedge clk) begin
    if (wbWrEn === 1'b1) begin
      if (sb.size() == 0) begin
        compare("unexpected_beat", 32'(wbWrEn), 32'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        compare("beat_cycle", cycleCount, e.cyc);
        compare("beat_rd", 32'(wbRd), 32'(e.rd));
        compare("beat_data", wbData, e.data);
        compare("beat_src", 32'(wbSrc), 32'(e.src));
      end
    end else if (sb.size() > 0 && sb[0].cyc == cycleCount) begin
      compare("missing_beat", 32'(wbWrEn), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic checkOutput();
    logic [4:0]  expReady;
    logic [31:0] expPend;
    logic        expBusy;
    if (!modelValid) return;
    expReady = '0;
    expPend  = '0;
    expBusy  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      expReady[i] = (modelQ[i].size() < DEPTH);
      if (modelQ[i].size() > 0) expBusy = 1'b1;
      for (int j = 0; j < modelQ[i].size(); j++) begin
        if (modelQ[i][j].rd != 5'd0) expPend[modelQ[i][j].rd] = 1'b1;
      end
    end
    compare("req_ready", 32'(reqReady), 32'(expReady));
    compare("pend_mask", pendMask, expPend);
    compare("arb_busy", 32'(arbBusy), 32'(expBusy));
    compare("wb_src_held", 32'(wbSrc), heldSrc);
    if (justReset) begin
      compare("reset_wb_data", wbData, 32'd0);
      compare("reset_wb_rd", 32'(wbRd), 32'd0);
      compare("reset_wb_en", 32'(wbWrEn), 32'd0);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check state, then advance the model past the rising edge.
  task automatic applyStimulus(input logic [4:0] sv, input logic [159:0] sd, input logic [24:0] sr,
                               input logic srst, output logic [4:0] accepted);
    int winner;
    logic [4:0] readyNow;
    reqValid = sv;
    reqData  = sd;
    reqRd    = sr;
    rst      = srst;
    checkOutput();
    accepted = '0;
    if (srst) begin
      for (int i = 0; i < NREQ; i++) modelQ[i].delete();
      modelLast  = NREQ - 1;
      heldSrc    = 0;
      modelValid = 1'b1;
      justReset  = 1'b1;
    end else begin
      justReset = 1'b0;
      for (int i = 0; i < NREQ; i++) readyNow[i] = (modelQ[i].size() < DEPTH);
      winner = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (winner < 0 && modelQ[(modelLast + k) % NREQ].size() > 0) winner = (modelLast + k) % NREQ;
      end
      if (winner >= 0) begin
        entry_t e;
        e = modelQ[winner].pop_front();
        modelLast = winner;
        heldSrc   = winner;
        if (e.rd != 5'd0) begin
          beat_t b;
          b.cyc  = cycleCount + 1;
          b.rd   = e.rd;
          b.data = e.data;
          b.src  = 3'(winner);
          sb.push_back(b);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (sv[i] && readyNow[i]) begin
          entry_t n;
          n.rd   = sr[i*5 +: 5];
          n.data = sd[i*32 +: 32];
          modelQ[i].push_back(n);
          accepted[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [4:0] a;
    for (int c = 0; c < n; c++) applyStimulus('0, '0, '0, 1'b0, a);
  endtask

  // Units in the mask offer beats with the given probability and hold an offer until it is accepted.
  task automatic runTraffic(input int cycles, input logic [4:0] mask, input int prob,
                            input int limitUnit, input int limit);
    logic [4:0]   offV;
    logic [159:0] offD;
    logic [24:0]  offR;
    logic [4:0]   a;
    int           issued[NREQ];
    offV = '0;
    offD = '0;
    offR = '0;
    for (int i = 0; i < NREQ; i++) issued[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!offV[i] && mask[i] && int'($urandom_range(0, 99)) < prob &&
            !(i == limitUnit && issued[i] >= limit)) begin
          offV[i] = 1'b1;
          offR[i*5 +: 5]   = 5'($urandom_range(0, 31));
          offD[i*32 +: 32] = $urandom;
          issued[i]++;
        end
      end
      applyStimulus(offV, offD, offR, 1'b0, a);
      offV = offV & ~a;
    end
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    reqData  = '0;
    reqRd    = '0;
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b1, acc);
    applyStimulus('0, '0, '0, 1'b1, acc);
    idle(2);

    v = 5'b00001; d = '0; r = '0;
    d[31:0] = 32'hDEADBEEF;
    r[4:0]  = 5'd5;
    applyStimulus(v, d, r, 1'b0, acc);
    idle(4);

    v = 5'b11111; d = '0; r = '0;
    for (int i = 0; i < NREQ; i++) begin
      d[i*32 +: 32] = 32'(17 * (i + 1));
      r[i*5 +: 5]   = 5'(i + 1);
    end
    applyStimulus(v, d, r, 1'b0, acc);
    idle(6);
    v = 5'b00010; d = '0; r = '0;
    d[63:32] = 32'h66;
    r[9:5]   = 5'd7;
    applyStimulus(v, d, r, 1'b0, acc);
    idle(3);

    runTraffic(12, 5'b10001, 100, -1, 0);
    idle(4);
    runTraffic(12, 5'b00101, 100, 2, 3);
    idle(6);

    v = 5'b01000; d = '0; r = '0;
    d[127:96] = 32'h1234;
    applyStimulus(v, d, r, 1'b0, acc);
    idle(4);

    runTraffic(300, 5'b11111, 55, -1, 0);
    idle(12);

    v = 5'b00111; d = '0; r = '0;
    for (int i = 0; i < 3; i++) begin
      d[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      r[i*5 +: 5]   = 5'(i + 3);
    end
    applyStimulus(v, d, r, 1'b0, acc);
    applyStimulus('0, '0, '0, 1'b1, acc);
    idle(6);

    compare("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
